// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the SM83 fetch stage
package cpu_fetch_pkg;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      F_OP = 3'd0,
      F_CB = 3'd1,
      F_LO = 3'd2,
      F_HI = 3'd3,
      OUT  = 3'd4
   } fetch_state_e;

   localparam logic [7:0] OPC_PREFIX_CB = 8'hCB;

   // Immediate-length code: number of immediate bytes (0, 1 or 2)
   localparam int IMM_LEN_W = 2;
   typedef logic [IMM_LEN_W-1:0] imm_len_t;

endpackage

// File: rtl/cpu_fetch_stage_opcode_imm_len.sv
// rtl/cpu_fetch_stage_opcode_imm_len.sv - unprefixed opcode to immediate byte count lookup
module opcode_imm_len
   import cpu_fetch_pkg::*;
(
   input  logic [7:0] i_Opcode,
   output imm_len_t   o_Len
);

   // Unlisted opcodes, including the illegal ones, carry no immediate
   always_comb begin
      o_Len = 2'd0;
      case (i_Opcode)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hE0, 8'hF0, 8'hE8, 8'hF8,
         8'h10:
            o_Len = 2'd1;
         8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
         8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
         8'hD2, 8'hD4, 8'hDA, 8'hDC,
         8'hEA, 8'hFA:
            o_Len = 2'd2;
         default:
            o_Len = 2'd0;
      endcase
   end

endmodule

// File: rtl/cpu_fetch_stage.sv
// rtl/cpu_fetch_stage.sv - SM83 instruction fetch front end; HALT_BUG_EN adds i_Halt_Bug
module cpu_fetch_stage
   import cpu_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        i_Clk,
   input  logic        i_nRst,
   output logic [15:0] o_Addr,
   output logic        o_Rd,
   input  logic [7:0]  i_Mem_Data,
   input  logic        i_Mem_Ready,
   input  logic        i_Stall,
   input  logic        i_Redirect,
   input  logic [15:0] i_Redirect_PC,
   output logic        o_Valid,
   output logic [7:0]  o_Opcode,
   output logic        o_Prefix_CB,
   output logic [15:0] o_Imm,
   output logic [15:0] o_Inst_PC,
   output logic [15:0] o_Next_PC
`ifdef HALT_BUG_EN
  ,input  logic        i_Halt_Bug
`endif
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  inst_pc_q, inst_pc_d;
   logic [15:0]  next_pc_q, next_pc_d;
   logic [15:0]  imm_q, imm_d;
   logic [7:0]   opcode_q, opcode_d;
   logic         prefix_q, prefix_d;
   logic         valid_q, valid_d;
   logic         rd_en_q, rd_en_d;
   imm_len_t     len_q, len_d;
   imm_len_t     byte_len;
   logic         accept;
   logic         hold_pc;

   opcode_imm_len u_imm_len (
      .i_Opcode (i_Mem_Data),
      .o_Len    (byte_len)
   );

`ifdef HALT_BUG_EN
   assign hold_pc = (state_q == F_OP) && i_Halt_Bug;
`else
   assign hold_pc = 1'b0;
`endif

   // Reads stop while an instruction is presented (no prefetch overlap)
   assign o_Rd        = rd_en_q && (state_q != OUT);
   assign o_Addr      = pc_q;
   assign accept      = o_Rd && i_Mem_Ready;

   assign o_Valid     = valid_q;
   assign o_Opcode    = opcode_q;
   assign o_Prefix_CB = prefix_q;
   assign o_Imm       = imm_q;
   assign o_Inst_PC   = inst_pc_q;
   assign o_Next_PC   = next_pc_q;

   // Next-state: byte assembly, then transfer completion, then redirect override
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_pc_d = inst_pc_q;
      next_pc_d = next_pc_q;
      imm_d     = imm_q;
      opcode_d  = opcode_q;
      prefix_d  = prefix_q;
      valid_d   = valid_q;
      len_d     = len_q;
      rd_en_d   = 1'b1;

      if (accept && !i_Redirect) begin
         pc_d = hold_pc ? pc_q : pc_q + 16'd1;
         case (state_q)
            F_OP: begin
               inst_pc_d = pc_q;
               imm_d     = 16'h0000;
               prefix_d  = 1'b0;
               opcode_d  = i_Mem_Data;
               len_d     = byte_len;
               if (i_Mem_Data == OPC_PREFIX_CB) begin
                  state_d = F_CB;
               end else if (byte_len == 2'd0) begin
                  state_d   = OUT;
                  valid_d   = 1'b1;
                  next_pc_d = pc_d;
               end else begin
                  state_d = F_LO;
               end
            end
            F_CB: begin
               opcode_d  = i_Mem_Data;
               prefix_d  = 1'b1;
               state_d   = OUT;
               valid_d   = 1'b1;
               next_pc_d = pc_d;
            end
            F_LO: begin
               imm_d = {8'h00, i_Mem_Data};
               if (len_q == 2'd2) begin
                  state_d = F_HI;
               end else begin
                  state_d   = OUT;
                  valid_d   = 1'b1;
                  next_pc_d = pc_d;
               end
            end
            F_HI: begin
               imm_d     = {i_Mem_Data, imm_q[7:0]};
               state_d   = OUT;
               valid_d   = 1'b1;
               next_pc_d = pc_d;
            end
            default: ;
         endcase
      end

      if ((state_q == OUT) && !i_Stall) begin
         state_d = F_OP;
         valid_d = 1'b0;
      end

      if (i_Redirect) begin
         pc_d    = i_Redirect_PC;
         state_d = F_OP;
         valid_d = 1'b0;
      end
   end

   // State and instruction field registers
   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state_q   <= F_OP;
         pc_q      <= RESET_PC;
         inst_pc_q <= RESET_PC;
         next_pc_q <= RESET_PC;
         imm_q     <= 16'h0000;
         opcode_q  <= 8'h00;
         prefix_q  <= 1'b0;
         valid_q   <= 1'b0;
         len_q     <= 2'd0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_pc_q <= inst_pc_d;
         next_pc_q <= next_pc_d;
         imm_q     <= imm_d;
         opcode_q  <= opcode_d;
         prefix_q  <= prefix_d;
         valid_q   <= valid_d;
         len_q     <= len_d;
         rd_en_q   <= rd_en_d;
      end
   end

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// tb/tb_cpu_fetch_stage.sv - self-checking bench for cpu_fetch_stage (HALT_BUG_EN optional)
module tb_cpu_fetch_stage;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk;
   logic        i_nRst;
   logic [15:0] o_Addr;
   logic        o_Rd;
   logic [7:0]  i_Mem_Data;
   logic        i_Mem_Ready;
   logic        i_Stall;
   logic        i_Redirect;
   logic [15:0] i_Redirect_PC;
   logic        o_Valid;
   logic [7:0]  o_Opcode;
   logic        o_Prefix_CB;
   logic [15:0] o_Imm;
   logic [15:0] o_Inst_PC;
   logic [15:0] o_Next_PC;
`ifdef HALT_BUG_EN
   logic        i_Halt_Bug;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [0:65535];
   assign i_Mem_Data = mem[o_Addr];

   typedef struct {
      logic [7:0]  op;
      logic        pfx;
      logic [15:0] imm;
      logic [15:0] ipc;
      logic [15:0] npc;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] len1_ops [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                                 8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                                 8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'h10};
   logic [7:0] len2_ops [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
                                 8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
                                 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA};

   cpu_fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .i_Clk         (clk),
      .i_nRst        (i_nRst),
      .o_Addr        (o_Addr),
      .o_Rd          (o_Rd),
      .i_Mem_Data    (i_Mem_Data),
      .i_Mem_Ready   (i_Mem_Ready),
      .i_Stall       (i_Stall),
      .i_Redirect    (i_Redirect),
      .i_Redirect_PC (i_Redirect_PC),
      .o_Valid       (o_Valid),
      .o_Opcode      (o_Opcode),
      .o_Prefix_CB   (o_Prefix_CB),
      .o_Imm         (o_Imm),
      .o_Inst_PC     (o_Inst_PC),
      .o_Next_PC     (o_Next_PC)
`ifdef HALT_BUG_EN
     ,.i_Halt_Bug    (i_Halt_Bug)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_len(input logic [7:0] op);
      for (int i = 0; i < 26; i++) if (len1_ops[i] == op) return 1;
      for (int i = 0; i < 17; i++) if (len2_ops[i] == op) return 2;
      return 0;
   endfunction

   // Called just after a negedge; the redirect takes effect on the next posedge
   task automatic do_redirect(input logic [15:0] pc);
      i_Redirect    = 1'b1;
      i_Redirect_PC = pc;
      @(posedge clk);
      #1;
      i_Redirect    = 1'b0;
   endtask

   // Counts negedges until o_Valid is seen (bounded); caller checks o_Valid
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!o_Valid && cycles < 200);
   endtask

   task automatic test_reset;
      i_nRst = 1'b0;
      i_Mem_Ready = 1'b1;
      i_Stall = 1'b0;
      i_Redirect = 1'b0;
      i_Redirect_PC = 16'h0000;
      repeat (3) @(negedge clk);
      n_tests++;
      if (o_Rd !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd: got %b expected 0", o_Rd);
      end
      n_tests++;
      if ({o_Valid, o_Opcode, o_Prefix_CB, o_Imm} !== 26'd0) begin
         n_fail++; $display("FAIL reset_fields: got %b/%h/%b/%h expected all zero",
                            o_Valid, o_Opcode, o_Prefix_CB, o_Imm);
      end
      n_tests++;
      if ({o_Inst_PC, o_Next_PC} !== {RESET_PC, RESET_PC}) begin
         n_fail++; $display("FAIL reset_pcs: got %h/%h expected %h/%h",
                            o_Inst_PC, o_Next_PC, RESET_PC, RESET_PC);
      end
      i_nRst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({o_Rd, o_Valid, o_Addr} !== {1'b1, 1'b0, 16'h0000}) begin
         n_fail++; $display("FAIL first_read: got rd=%b valid=%b addr=%h expected 1/0/0000",
                            o_Rd, o_Valid, o_Addr);
      end
      @(negedge clk);
      n_tests++;
      if ({o_Valid, o_Rd, o_Opcode, o_Prefix_CB, o_Inst_PC, o_Next_PC} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0001}) begin
         n_fail++; $display("FAIL reset_nop: got v=%b rd=%b op=%h pfx=%b ipc=%h npc=%h expected 1/0/00/0/0000/0001",
                            o_Valid, o_Rd, o_Opcode, o_Prefix_CB, o_Inst_PC, o_Next_PC);
      end
   endtask

   task automatic test_jp_imm16;
      int cyc;
      mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'h50; mem[16'h0002] = 8'h01;
      do_redirect(16'h0000);
      wait_valid(cyc);
      n_tests++;
      if (o_Valid !== 1'b1 || cyc != 4) begin
         n_fail++; $display("FAIL jp_latency: got valid=%b cycles=%0d expected 1/4", o_Valid, cyc);
      end
      n_tests++;
      if ({o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC} !==
          {8'hC3, 1'b0, 16'h0150, 16'h0000, 16'h0003}) begin
         n_fail++; $display("FAIL jp_fields: got op=%h pfx=%b imm=%h ipc=%h npc=%h expected C3/0/0150/0000/0003",
                            o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC);
      end
   endtask

   task automatic test_cb_prefix;
      int cyc;
      mem[16'h0010] = 8'hCB; mem[16'h0011] = 8'h37;
      do_redirect(16'h0010);
      wait_valid(cyc);
      n_tests++;
      if (o_Valid !== 1'b1 || cyc != 3) begin
         n_fail++; $display("FAIL cb_latency: got valid=%b cycles=%0d expected 1/3", o_Valid, cyc);
      end
      n_tests++;
      if ({o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC} !==
          {8'h37, 1'b1, 16'h0000, 16'h0010, 16'h0012}) begin
         n_fail++; $display("FAIL cb_fields: got op=%h pfx=%b imm=%h ipc=%h npc=%h expected 37/1/0000/0010/0012",
                            o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC);
      end
   endtask

   task automatic test_mem_wait;
      int cyc;
      mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h42;
      i_Mem_Ready = 1'b1;
      do_redirect(16'h0000);
      @(negedge clk);
      @(negedge clk);
      i_Mem_Ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if ({o_Addr, o_Rd, o_Valid} !== {16'h0001, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL wait_hold%0d: got addr=%h rd=%b valid=%b expected 0001/1/0",
                               k, o_Addr, o_Rd, o_Valid);
         end
      end
      i_Mem_Ready = 1'b1;
      wait_valid(cyc);
      n_tests++;
      if ({o_Valid, o_Opcode, o_Imm, o_Next_PC} !== {1'b1, 8'h3E, 16'h0042, 16'h0002}) begin
         n_fail++; $display("FAIL wait_result: got v=%b op=%h imm=%h npc=%h expected 1/3E/0042/0002",
                            o_Valid, o_Opcode, o_Imm, o_Next_PC);
      end
   endtask

   task automatic test_stall_redirect;
      int cyc;
      mem[16'h0300] = 8'h3E; mem[16'h0301] = 8'h55;
      mem[16'h0302] = 8'hC3; mem[16'h0303] = 8'h00; mem[16'h0304] = 8'h40;
      mem[16'h0100] = 8'h00;
      i_Mem_Ready = 1'b1;
      do_redirect(16'h0300);
      wait_valid(cyc);
      i_Stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_tests++;
         if ({o_Valid, o_Rd, o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC} !==
             {1'b1, 1'b0, 8'h3E, 1'b0, 16'h0055, 16'h0300, 16'h0302}) begin
            n_fail++; $display("FAIL stall_hold%0d: got v=%b rd=%b op=%h imm=%h ipc=%h npc=%h expected 1/0/3E/0055/0300/0302",
                               k, o_Valid, o_Rd, o_Opcode, o_Imm, o_Inst_PC, o_Next_PC);
         end
      end
      i_Stall = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({o_Valid, o_Rd, o_Addr} !== {1'b0, 1'b1, 16'h0302}) begin
         n_fail++; $display("FAIL stall_release: got v=%b rd=%b addr=%h expected 0/1/0302",
                            o_Valid, o_Rd, o_Addr);
      end
      @(negedge clk);
      do_redirect(16'h0100);
      @(negedge clk);
      n_tests++;
      if ({o_Valid, o_Rd, o_Addr} !== {1'b0, 1'b1, 16'h0100}) begin
         n_fail++; $display("FAIL redirect_mid: got v=%b rd=%b addr=%h expected 0/1/0100",
                            o_Valid, o_Rd, o_Addr);
      end
      wait_valid(cyc);
      n_tests++;
      if ({o_Valid, o_Opcode, o_Inst_PC, o_Next_PC} !== {1'b1, 8'h00, 16'h0100, 16'h0101}) begin
         n_fail++; $display("FAIL redirect_inst: got v=%b op=%h ipc=%h npc=%h expected 1/00/0100/0101",
                            o_Valid, o_Opcode, o_Inst_PC, o_Next_PC);
      end
   endtask

   task automatic test_pc_wrap;
      int cyc;
      mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
      do_redirect(16'hFFFE);
      wait_valid(cyc);
      n_tests++;
      if ({o_Valid, o_Opcode, o_Imm, o_Inst_PC, o_Next_PC} !==
          {1'b1, 8'h01, 16'h1234, 16'hFFFE, 16'h0001} || cyc != 4) begin
         n_fail++; $display("FAIL pc_wrap: got v=%b op=%h imm=%h ipc=%h npc=%h cyc=%0d expected 1/01/1234/FFFE/0001/4",
                            o_Valid, o_Opcode, o_Imm, o_Inst_PC, o_Next_PC, cyc);
      end
   endtask

   // Every opcode once in random order, random memory wait and downstream stall
   task automatic test_random_stream;
      logic [7:0]  ops [256];
      logic [7:0]  tmp, b1, b2;
      logic [15:0] a;
      int          j, n;
      exp_t        e;
      for (int i = 0; i < 256; i++) ops[i] = i[7:0];
      for (int i = 255; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = ops[i]; ops[i] = ops[j]; ops[j] = tmp;
      end
      exp_q.delete();
      a = 16'h4000;
      for (int i = 0; i < 256; i++) begin
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         e.ipc = a;
         mem[a] = ops[i];
         if (ops[i] == 8'hCB) begin
            mem[a + 16'd1] = b1;
            e.op = b1; e.pfx = 1'b1; e.imm = 16'h0000; a = a + 16'd2;
         end else begin
            n = ref_len(ops[i]);
            e.op = ops[i]; e.pfx = 1'b0;
            if (n >= 1) mem[a + 16'd1] = b1;
            if (n == 2) mem[a + 16'd2] = b2;
            e.imm = (n == 2) ? {b2, b1} : (n == 1) ? {8'h00, b1} : 16'h0000;
            a = a + 16'(n + 1);
         end
         e.npc = a;
         exp_q.push_back(e);
      end
      do_redirect(16'h4000);
      for (int cyc = 0; cyc < 20000 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (o_Valid) begin
            e = exp_q[0];
            n_tests++;
            if ({o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC} !==
                {e.op, e.pfx, e.imm, e.ipc, e.npc}) begin
               n_fail++; $display("FAIL random_inst: got op=%h pfx=%b imm=%h ipc=%h npc=%h expected %h/%b/%h/%h/%h",
                                  o_Opcode, o_Prefix_CB, o_Imm, o_Inst_PC, o_Next_PC,
                                  e.op, e.pfx, e.imm, e.ipc, e.npc);
            end
            i_Stall = ($urandom_range(0, 2) == 0);
            if (!i_Stall) void'(exp_q.pop_front());
         end else begin
            i_Stall = ($urandom_range(0, 1) == 0);
         end
         i_Mem_Ready = ($urandom_range(0, 3) != 0);
      end
      i_Stall = 1'b0;
      i_Mem_Ready = 1'b1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL random_timeout: got %0d instructions outstanding expected 0", exp_q.size());
      end
   endtask

`ifdef HALT_BUG_EN
   task automatic test_halt_bug;
      int cyc;
      mem[16'h0200] = 8'h3C; mem[16'h0201] = 8'h00;
      i_Mem_Ready = 1'b1;
      do_redirect(16'h0200);
      i_Halt_Bug = 1'b1;
      wait_valid(cyc);
      i_Halt_Bug = 1'b0;
      n_tests++;
      if ({o_Valid, o_Opcode, o_Inst_PC, o_Next_PC} !== {1'b1, 8'h3C, 16'h0200, 16'h0200}) begin
         n_fail++; $display("FAIL halt_first: got v=%b op=%h ipc=%h npc=%h expected 1/3C/0200/0200",
                            o_Valid, o_Opcode, o_Inst_PC, o_Next_PC);
      end
      wait_valid(cyc);
      n_tests++;
      if ({o_Valid, o_Opcode, o_Inst_PC, o_Next_PC} !== {1'b1, 8'h3C, 16'h0200, 16'h0201}) begin
         n_fail++; $display("FAIL halt_second: got v=%b op=%h ipc=%h npc=%h expected 1/3C/0200/0201",
                            o_Valid, o_Opcode, o_Inst_PC, o_Next_PC);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
`ifdef HALT_BUG_EN
      i_Halt_Bug = 1'b0;
`endif
      test_reset();
      test_jp_imm16();
      test_cb_prefix();
      test_mem_wait();
      test_stall_redirect();
      test_pc_wrap();
`ifdef HALT_BUG_EN
      test_halt_bug();
`endif
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_stage.md
Name: cpu_fetch_stage

Overview:
- Fetch front end of the SM83-class CPU. It sits directly upstream of the fetch/decode pipeline register.
- Reads instruction bytes over the byte-wide memory bus and assembles one complete instruction: opcode, CB-prefix flag and 0/1/2 immediate bytes.
- Presents the instruction with a valid/stall handshake. It drives the downstream register's enable through o_Valid && !i_Stall.
- Owns the program counter and accepts redirects from branches and interrupts.

Parameters:
- RESET_PC, 16'h0000: PC loaded on reset (boot ROM entry).

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_nRst  in  1  asynchronous active-low reset.
- o_Addr  out  16  memory read address.
- o_Rd  out  1  memory read request.
- i_Mem_Data  in  8  read data, valid when i_Mem_Ready=1.
- i_Mem_Ready  in  1  read completes this cycle.
- i_Stall  in  1  downstream cannot accept.
- i_Redirect  in  1  load new PC and flush.
- i_Redirect_PC  in  16  target PC.
- o_Valid  out  1  instruction outputs valid.
- o_Opcode  out  8  opcode byte; the byte after CB when prefixed.
- o_Prefix_CB  out  1  instruction was CB-prefixed.
- o_Imm  out  16  immediate: low byte first, {hi,lo}; upper byte 0 for 1-byte immediates.
- o_Inst_PC  out  16  address of the first byte of the instruction.
- o_Next_PC  out  16  address following the instruction.
- i_Halt_Bug  in  1  optional; present only with HALT_BUG_EN.

Behaviour:
- Reset (async):
  - PC=RESET_PC, state=F_OP.
  - o_Valid=0, o_Opcode=0, o_Prefix_CB=0, o_Imm=0.
  - o_Inst_PC=RESET_PC, o_Next_PC=RESET_PC.
  - o_Rd=0 during reset; o_Rd=1 from the first clock edge after reset release.
- Memory rules:
  - o_Addr=PC whenever o_Rd=1.
  - A byte is accepted on any edge with o_Rd && i_Mem_Ready. PC increments by 1 (16-bit wrap: FFFF->0000).
  - While i_Mem_Ready=0, address and state hold.
- States and transitions:
  - F_OP: accept byte, latch o_Inst_PC=PC. Byte CB -> F_CB. Otherwise opcode=byte; then by length 0 -> OUT, 1 -> F_LO, 2 -> F_LO.
  - F_CB: accept byte -> opcode=byte, Prefix_CB=1 -> OUT. CB instructions take no immediates.
  - F_LO: accept -> imm[7:0]. Go to F_HI if length is 2, else OUT.
  - F_HI: accept -> imm[15:8] -> OUT.
  - OUT: o_Valid=1, o_Rd=0, o_Next_PC=PC. When !i_Stall, the transfer completes and the state returns to F_OP; o_Valid falls on the next edge. No prefetch overlap, so throughput is 1 instruction per (bytes+1) cycles minimum.
- Stall rule: outputs are stable while o_Valid && i_Stall.
- Redirect (highest priority, any state, including mid-fetch or mid-wait):
  - Next edge: PC=i_Redirect_PC, state=F_OP, o_Valid=0.
  - A byte completing on the same edge is discarded.
  - A redirect coinciding with a transfer lets the transfer complete; downstream sees it this cycle.
- Length table, 1 immediate byte:
  - 06 0E 16 1E 26 2E 36 3E, 18 20 28 30 38.
  - C6 CE D6 DE E6 EE F6 FE, E0 F0 E8 F8.
  - 10 (STOP operand).
- Length table, 2 immediate bytes:
  - 01 11 21 31 08, C2 C3 C4 CA CC CD, D2 D4 DA DC, EA FA.
- Length table: all other opcodes take 0 immediate bytes, including the illegal ones.

Optional Feature:
- Macro: HALT_BUG_EN.
- Defined: port i_Halt_Bug exists. If i_Halt_Bug=1 on the F_OP accept edge, PC does not increment, so the opcode byte is re-read as the next byte. The flag applies to that single accept only.
- Undefined: port absent; PC always increments.

Decomposition:
- Package cpu_fetch_pkg:
  - state encoding constants F_OP, F_CB, F_LO, F_HI, OUT.
  - OPC_PREFIX_CB=8'hCB.
  - immediate-length code width (2 bits).
- Sub-module: opcode_imm_len, a combinational 8-bit -> 2-bit length lookup. It is reused by the decoder.
- The instruction output fields are held in internal registers, not Pipeline_Register instances. Redirect and flush priority differs from that block.

Test Plan:
- Reset release with memory at 0000=00 (NOP), always ready -> o_Valid at the cycle after the accept; o_Opcode=00, o_Inst_PC=0000, o_Next_PC=0001.
- Bytes C3 50 01 (JP a16) -> o_Imm=0150, o_Next_PC=0003, 3 read cycles, then o_Valid.
- Bytes CB 37 -> o_Prefix_CB=1, o_Opcode=37, o_Next_PC=0002.
- Bytes 3E 42 with i_Mem_Ready low for 3 cycles on the second byte -> o_Addr holds 0001; result o_Imm=0042.
- i_Stall=1 for 4 cycles during OUT -> outputs unchanged and o_Rd=0. Stall released, then a redirect to 0100 mid-fetch of the next instruction -> o_Valid=0; next accept at o_Addr=0100.
- With HALT_BUG_EN: i_Halt_Bug=1 on F_OP for byte 3C at 0200 -> two consecutive INC A instructions delivered, both o_Inst_PC=0200.
